// File: rtl/boot_loader.sv
// boot_loader
//
// Serial boot loader.
// It receives a framed image over an 8N1 UART line and writes the payload
// into the system BRAM through a byte write port. The 6502 core is held in
// reset until a complete frame with a matching checksum has been stored.
//
// Frame on the wire: A5, LEN_LO, LEN_HI, LEN payload bytes, CSUM.
// CSUM is the modulo-256 sum of the payload bytes.
//
// Parameters
//   CLKS_PER_BIT  i_clk cycles per UART bit (>= 4, even)
//   LOAD_ADDR     RAM address of the first payload byte
//   RAM_DEPTH     RAM size in bytes; bounds the accepted payload length
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous reset, active-low
//   i_rx          asynchronous UART receive line, idles high
//   o_addr        RAM write address
//   o_data        RAM write data
//   o_we          one-cycle RAM write strobe
//   o_core_rst_n  core reset, active-low; released only after a good load
//   o_busy        a frame is in progress
//   o_err         last frame failed; held until the next sync byte
module boot_loader #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [15:0] LOAD_ADDR    = 16'h0000,
    parameter int          RAM_DEPTH    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_we,
    output logic        o_core_rst_n,
    output logic        o_busy,
    output logic        o_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int            MAX_LEN  = RAM_DEPTH - int'(LOAD_ADDR);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        L_SYNC, L_LEN_LO, L_LEN_HI, L_DATA, L_CSUM, L_DONE, L_ERR
    } ld_state_t;

    // Input synchroniser and edge history; all reset high to match line idle.
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_vld;
    logic          byte_ferr;

    ld_state_t   ld_state_q, ld_state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        we_q, we_d;
    logic [15:0] new_len;
    logic [15:0] idx_inc;

    assign new_len = {shift_q, len_q[7:0]};
    assign idx_inc = idx_q + 16'd1;

    // UART receiver. byte_vld / byte_ferr pulse in the cycle the stop bit is
    // sampled; shift_q already holds the complete byte in that cycle.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_vld   = 1'b0;
        byte_ferr  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    // Line back high at mid start bit: a glitch, not a frame.
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_vld   = rx_sync_q;
                    byte_ferr  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Loader FSM; acts on a byte in the same cycle it completes so the
    // registered write strobe appears one cycle later.
    always_comb begin
        ld_state_d = ld_state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_d       = 1'b0;
        if (byte_ferr) begin
            if (ld_state_q != L_DONE) begin
                ld_state_d = L_ERR;
            end
        end else if (byte_vld) begin
            case (ld_state_q)
                L_SYNC, L_ERR: begin
                    if (shift_q == SYNC_BYTE) begin
                        ld_state_d = L_LEN_LO;
                    end
                end
                L_LEN_LO: begin
                    len_d      = {8'h00, shift_q};
                    ld_state_d = L_LEN_HI;
                end
                L_LEN_HI: begin
                    len_d = new_len;
                    idx_d = 16'd0;
                    sum_d = 8'd0;
                    if (int'(new_len) > MAX_LEN) begin
                        ld_state_d = L_ERR;
                    end else if (new_len == 16'd0) begin
                        ld_state_d = L_CSUM;
                    end else begin
                        ld_state_d = L_DATA;
                    end
                end
                L_DATA: begin
                    we_d   = 1'b1;
                    addr_d = LOAD_ADDR + idx_q;
                    data_d = shift_q;
                    sum_d  = sum_q + shift_q;
                    idx_d  = idx_inc;
                    if (idx_inc == len_q) begin
                        ld_state_d = L_CSUM;
                    end
                end
                L_CSUM: begin
                    ld_state_d = (shift_q == sum_q) ? L_DONE : L_ERR;
                end
                default: ld_state_d = ld_state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            ld_state_q <= L_SYNC;
            addr_q     <= 16'd0;
            data_q     <= 8'd0;
            we_q       <= 1'b0;
        end else begin
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            ld_state_q <= ld_state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
        end
    end

    // Pure datapath: always (re)loaded before being consumed.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
        len_q   <= len_d;
        idx_q   <= idx_d;
        sum_q   <= sum_d;
    end

    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_we         = we_q;
    assign o_core_rst_n = (ld_state_q == L_DONE);
    assign o_err        = (ld_state_q == L_ERR);
    assign o_busy       = (ld_state_q == L_LEN_LO) || (ld_state_q == L_LEN_HI) ||
                          (ld_state_q == L_DATA)   || (ld_state_q == L_CSUM);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: UART frames driven bit by bit, RAM writes
// captured by a monitor, outputs compared against hand-computed values.
module tb_boot_loader;

    localparam int          CPB = 16;
    localparam logic [15:0] LA  = 16'h00F0;
    localparam int          RD  = 1024;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic [15:0] o_addr;
    logic [7:0]  o_data;
    logic        o_we;
    logic        o_core_rst_n;
    logic        o_busy;
    logic        o_err;

    int checks = 0;
    int fails  = 0;
    int base   = 0;

    int          wr_n    = 0;
    int          we_long = 0;
    logic        we_prev = 1'b0;
    logic [15:0] wr_addr [64];
    logic [7:0]  wr_data [64];

    always #5 clk = ~clk;

    boot_loader #(
        .CLKS_PER_BIT (CPB),
        .LOAD_ADDR    (LA),
        .RAM_DEPTH    (RD)
    ) u_dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_rx         (rx),
        .o_addr       (o_addr),
        .o_data       (o_data),
        .o_we         (o_we),
        .o_core_rst_n (o_core_rst_n),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    // Write monitor: logs every strobed write and flags strobes wider than 1.
    always @(negedge clk) begin
        if (o_we) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] <= o_addr;
                wr_data[wr_n] <= o_data;
            end
            wr_n <= wr_n + 1;
            if (we_prev) we_long <= we_long + 1;
        end
        we_prev <= o_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_bit);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] csum);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(csum, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, 32'(o_addr), 32'h0);
        chk({tag, "_data"}, 32'(o_data), 32'h0);
        chk({tag, "_we"},   32'(o_we), 32'h0);
        chk({tag, "_core"}, 32'(o_core_rst_n), 32'h0);
        chk({tag, "_busy"}, 32'(o_busy), 32'h0);
        chk({tag, "_err"},  32'(o_err), 32'h0);
    endtask

    task automatic chk_three_writes(input string tag, input int b);
        chk({tag, "_cnt"},   32'(wr_n - b), 32'd3);
        chk({tag, "_a0"},    32'(wr_addr[b]),     32'h00F0);
        chk({tag, "_d0"},    32'(wr_data[b]),     32'h11);
        chk({tag, "_a1"},    32'(wr_addr[b + 1]), 32'h00F1);
        chk({tag, "_d1"},    32'(wr_data[b + 1]), 32'h22);
        chk({tag, "_a2"},    32'(wr_addr[b + 2]), 32'h00F2);
        chk({tag, "_d2"},    32'(wr_data[b + 2]), 32'h33);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        chk_reset_vals("rst_in");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_reset_vals("rst_out");

        // Noise before sync, a sub-bit glitch mid-frame, then an empty frame.
        base = wr_n;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        chk("noise_busy", 32'(o_busy), 32'h0);
        chk("noise_err",  32'(o_err), 32'h0);
        send_byte(8'hA5, 1'b1);
        chk("sync_busy", 32'(o_busy), 32'h1);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_busy", 32'(o_busy), 32'h1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("empty_core", 32'(o_core_rst_n), 32'h1);
        chk("empty_busy", 32'(o_busy), 32'h0);
        chk("empty_err",  32'(o_err), 32'h0);
        chk("empty_wr",   32'(wr_n - base), 32'd0);
        send_byte(8'hA5, 1'b1);
        chk("done_sticky", 32'(o_core_rst_n), 32'h1);

        // Good frame.
        do_reset();
        chk("post_done_core", 32'(o_core_rst_n), 32'h0);
        base = wr_n;
        send_frame(8'h66);
        chk_three_writes("good", base);
        chk("good_core", 32'(o_core_rst_n), 32'h1);
        chk("good_err",  32'(o_err), 32'h0);
        chk("good_busy", 32'(o_busy), 32'h0);
        chk("good_addr_hold", 32'(o_addr), 32'h00F2);
        chk("good_data_hold", 32'(o_data), 32'h33);

        // Bad checksum, then recovery with the good frame.
        do_reset();
        base = wr_n;
        send_frame(8'h67);
        chk_three_writes("badcs", base);
        chk("badcs_err",  32'(o_err), 32'h1);
        chk("badcs_core", 32'(o_core_rst_n), 32'h0);
        chk("badcs_busy", 32'(o_busy), 32'h0);
        send_byte(8'hA5, 1'b1);
        chk("resync_err",  32'(o_err), 32'h0);
        chk("resync_busy", 32'(o_busy), 32'h1);
        base = wr_n;
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h66, 1'b1);
        chk_three_writes("recover", base);
        chk("recover_core", 32'(o_core_rst_n), 32'h1);
        chk("recover_err",  32'(o_err), 32'h0);

        // Length bound: RD - LA = 784 = 0x0310.
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h03, 1'b1);
        chk("len311_err",  32'(o_err), 32'h1);
        chk("len311_busy", 32'(o_busy), 32'h0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h04, 1'b1);
        chk("len401_err", 32'(o_err), 32'h1);
        chk("len_wr",     32'(wr_n - base), 32'd0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h03, 1'b1);
        chk("len310_err",  32'(o_err), 32'h0);
        chk("len310_busy", 32'(o_busy), 32'h1);

        // Framing error on the second payload byte.
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        chk("ferr_err",  32'(o_err), 32'h1);
        chk("ferr_core", 32'(o_core_rst_n), 32'h0);
        chk("ferr_wr",   32'(wr_n - base), 32'd1);

        // Reset pulse in the middle of payload byte 2 (while the line is high).
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        chk("mid_addr_before", 32'(o_addr), 32'h00F0);
        bit_time(1'b0);
        bit_time(1'b0);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_rst");
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("mid_idle_busy", 32'(o_busy), 32'h0);
        chk("mid_idle_err",  32'(o_err), 32'h0);
        chk("mid_wr_before", 32'(wr_n - base), 32'd1);
        base = wr_n;
        send_frame(8'h66);
        chk_three_writes("mid_reload", base);
        chk("mid_reload_core", 32'(o_core_rst_n), 32'h1);

        chk("we_width", 32'(we_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial boot loader that fills the system BRAM before the 6502 core runs. It receives an 8N1 UART frame on `i_rx` and writes the payload bytes into RAM through a byte write port starting at `LOAD_ADDR`. It holds the core in reset until a complete frame with a valid checksum has been stored. It sits upstream of the core/BRAM top level and shares that level's RAM write port: its writes are multiplexed in while `o_core_rst_n` is low.

## Interface
- `CLKS_PER_BIT`, 16 — `i_clk` cycles per UART bit; ≥4, even
- `LOAD_ADDR`, 16'h0000 — RAM address of first payload byte
- `RAM_DEPTH`, 1024 — RAM size in bytes; bounds the legal payload length

- `i_clk`  in  1  — system clock; sole clock
- `i_rst`  in  1  — reset; synchronous, active-low
- `i_rx`  in  1  — asynchronous UART receive line; idles high
- `o_addr`  out  16  — RAM write address
- `o_data`  out  8  — RAM write data
- `o_we`  out  1  — one-cycle RAM write strobe
- `o_core_rst_n`  out  1  — core reset, active-low; high only after a successful load
- `o_busy`  out  1  — a frame is in progress
- `o_err`  out  1  — last frame failed; sticky until the next sync byte

## Operation
- **Input synchroniser.** `i_rx` passes through a 2-flop synchroniser; all logic uses the synchronised value.
- **UART receiver (8N1, LSB first).**
  - Start detect: falling edge on the synchronised line.
  - Start bit is re-sampled at `CLKS_PER_BIT/2`. If it reads high, this is a false start: return to idle and produce no byte.
  - Data bits are sampled every `CLKS_PER_BIT` from that midpoint, then the stop bit.
  - Stop bit = 0 is a framing error: the byte is discarded and the loader FSM goes to ERR (ignored in DONE).
- **Frame format.** `0xA5` sync, `LEN_LO`, `LEN_HI`, `LEN` payload bytes, `CSUM`.
  - `CSUM` = 8-bit modulo-256 sum of the payload bytes.
- **Loader FSM states:** SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - SYNC: `0xA5` → LEN_LO. Any other byte is ignored.
  - LEN_LO → LEN_HI on a byte (latch the low length byte).
  - LEN_HI, on a byte:
    - If `LEN > RAM_DEPTH - LOAD_ADDR` → ERR.
    - Else if `LEN == 0` → CSUM.
    - Else → DATA. Clear the index and the running sum.
  - DATA, per byte:
    - Write it at `LOAD_ADDR + index` (16-bit, wraps modulo 2^16).
    - Add it to the sum (8-bit wrap) and increment the index.
    - After byte `LEN` → CSUM.
  - CSUM: a byte equal to the sum → DONE; otherwise → ERR.
  - DONE: terminal until reset. Received bytes are ignored, `o_core_rst_n` = 1.
  - ERR: `o_err` = 1. A `0xA5` byte → LEN_LO and clears `o_err`; other bytes are ignored.
- **Outputs.**
  - `o_busy` = 1 in LEN_LO, LEN_HI, DATA and CSUM.
  - `o_core_rst_n` = 1 only in DONE.
  - Bytes already written before an error stay in RAM; no rollback.
- **Reset mid-operation.** Asserting `i_rst` during any state or bit aborts immediately: the FSM returns to SYNC and the receiver to idle. The partially written RAM is left as is.

## Timing
- **Reset values:** `o_addr` = 0, `o_data` = 0, `o_we` = 0, `o_core_rst_n` = 0, `o_busy` = 0, `o_err` = 0. The receiver is idle and the FSM is in SYNC.
- **Byte complete** = the cycle the stop bit is sampled. The FSM acts on the byte the following cycle.
- **Write pulse.** For a payload byte, `o_we` = 1 for exactly one cycle, 1 cycle after byte complete. `o_addr` and `o_data` are valid in the same cycle and hold their values until the next write.
- **Release.** `o_core_rst_n` rises 1 cycle after the CSUM byte completes. `o_err` rises 1 cycle after the failing byte completes.
- **No overlap.** Minimum byte spacing is 10 bit times, so a write can never coincide with the next byte's completion; no buffering is needed.
- **End-to-end latency.** From the `i_rx` falling edge to byte complete: 2 sync cycles + 9.5 × `CLKS_PER_BIT` (±1 cycle).

## Test plan
- Frame `A5 03 00 11 22 33 66` at `LOAD_ADDR`=0x00F0:
  - writes 0x11/0x22/0x33 at 0x00F0/0x00F1/0x00F2, one `o_we` pulse each;
  - then `o_core_rst_n` = 1, `o_err` = 0, `o_busy` = 0.
- Same frame with CSUM 0x67 → three writes, then `o_err` = 1 and `o_core_rst_n` stays 0. Resending the good frame → `o_err` = 0, then DONE.
- Bytes `00 FF` then `A5 00 00 00` → first two ignored with no writes; DONE with zero writes.
- `LEN` = 0x0401 with `RAM_DEPTH`=1024, `LOAD_ADDR`=0 → ERR right after `LEN_HI`, no writes.
- Edge cases:
  - A 0.3-bit low glitch on `i_rx` → no byte produced.
  - A byte with stop bit 0 during DATA → ERR.
- `i_rst` low for 1 cycle midway through payload byte 2 → all outputs return to reset values. A fresh full frame afterwards loads correctly.
